fp_accum_seq: RTL

- Sequencer that sums a stream of IEEE-754 single-precision operands into one scalar, for CNN window and channel reductions.
- Owns a single fp_add instance. It drives the adder's A_FP/B_FP from registers and captures the adder's {sign, exponent, mantissa} result back into an accumulator.
- Accepts operands over a valid/ready handshake and emits one registered sum pulse per accumulation job.

---
 rtl/fp_accum_seq_if.sv | 22 ++
 rtl/fp_accum_seq.sv | 107 ++++++++++
 2 files changed

// File: rtl/fp_accum_seq_if.sv
// fp_accum_seq_if: operand stream handshake into the accumulation sequencer.
//   in_data  : IEEE-754 single-precision operand
//   in_valid : in_data is valid (driven by the producer)
//   in_ready : sequencer accepts in_data this cycle (driven by the sequencer)
// master modport is the operand producer, slave modport is the sequencer.
interface fp_accum_seq_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/fp_accum_seq.sv
// fp_accum_seq: sums a stream of IEEE-754 single-precision operands into one
// scalar using a single external fp_add instance, strictly in arrival order
// (((0 + x0) + x1) + ...).
//
// Ports:
//   clk       : system clock, all state updates on the rising edge
//   reset     : synchronous, active-high reset
//   start     : begin a job, sampled only in IDLE
//   len       : number of operands in the job, sampled with start
//   stream    : operand handshake (in_data / in_valid / in_ready), slave side
//   add_a     : to fp_add A_FP, copy of the accumulator
//   add_b     : to fp_add B_FP, the accepted operand
//   add_sum   : from fp_add, {sign, exponent[7:0], mantissa[22:0]}
//   sum       : final accumulated value, held until the next job completes
//   sum_valid : one-cycle pulse, sum is valid
//   busy      : high in every state except IDLE
module fp_accum_seq #(
    parameter int COUNT_W = 8,
    parameter int ADD_LAT = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COUNT_W-1:0] len,
    fp_accum_seq_if.slave      stream,
    output logic [31:0]        add_a,
    output logic [31:0]        add_b,
    input  logic [31:0]        add_sum,
    output logic [31:0]        sum,
    output logic               sum_valid,
    output logic               busy
);

    localparam int WAIT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(ADD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state;
    logic [31:0]        acc;
    logic [COUNT_W-1:0] remaining;
    logic [WAIT_W-1:0]  waitcnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            acc       <= '0;
            add_a     <= '0;
            add_b     <= '0;
            sum       <= '0;
            sum_valid <= 1'b0;
            remaining <= '0;
            waitcnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc       <= '0;
                        remaining <= len;
                        state     <= (len == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    // in_ready is high throughout FETCH, so in_valid alone completes the handshake.
                    if (stream.in_valid) begin
                        add_a     <= acc;
                        add_b     <= stream.in_data;
                        remaining <= remaining - COUNT_W'(1);
                        waitcnt   <= WAIT_LOAD;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (waitcnt != '0) begin
                        waitcnt <= waitcnt - WAIT_W'(1);
                    end else begin
                        acc   <= add_sum;
                        state <= (remaining == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_DONE: begin
                    // DONE spans two cycles: the first publishes acc and raises the
                    // pulse, the second drops it and returns to IDLE.
                    if (!sum_valid) begin
                        sum       <= acc;
                        sum_valid <= 1'b1;
                    end else begin
                        sum_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        stream.in_ready = (state == S_FETCH);
        busy            = (state != S_IDLE);
    end

endmodule
